// File: rtl/gate_delay_monitor_if.sv
// Observation bus between a gate-under-test stimulus side and gate_delay_monitor.
//   A, Z      : gate input / gate output samples, synchronous to the monitor clock
//   DONE      : measurement-complete pulse, with DELAY / EDGE / ERR
//   TIMEOUT   : no Z edge answered the last A edge in time
//   SPUR      : Z edge seen with no pending A edge
//   ERR_CNT   : saturating event counter
// master = stimulus / observing side, slave = monitor.
interface gate_delay_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             A;
  logic             Z;
  logic             DONE;
  logic [CNT_W-1:0] DELAY;
  logic             EDGE;
  logic             ERR;
  logic             TIMEOUT;
  logic             SPUR;
  logic [7:0]       ERR_CNT;

  modport master (
    output A, Z,
    input  DONE, DELAY, EDGE, ERR, TIMEOUT, SPUR, ERR_CNT
  );

  modport slave (
    input  A, Z,
    output DONE, DELAY, EDGE, ERR, TIMEOUT, SPUR, ERR_CNT
  );
endinterface

// File: rtl/gate_delay_monitor.sv
// Synchronous gate timing observer: measures A-edge to Z-edge delay in clock
// cycles, classifies the Z transition as rise/fall and checks it against the
// expected rise/fall delay within a tolerance.
// Ports:
//   CLK  - clock, rising-edge sampling
//   RST  - synchronous active-high reset
//   mon  - slave modport of gate_delay_monitor_if (A/Z in, result pulses out)
module gate_delay_monitor #(
  parameter int unsigned RISE_DLY = 5,
  parameter int unsigned FALL_DLY = 3,
  parameter int unsigned TOL      = 0,
  parameter int unsigned MAX_WAIT = 63,
  parameter int unsigned CNT_W    = 8
) (
  input logic                 CLK,
  input logic                 RST,
  gate_delay_monitor_if.slave mon
);

  localparam int unsigned CW1     = CNT_W + 1;
  localparam logic [7:0]  CNT_SAT = 8'hFF;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e           state_q;
  logic             a_q, z_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] delay_q;
  logic             done_q, edge_q, err_q, tmo_q, spur_q;
  logic [7:0]       err_cnt_q;

  logic             a_edge_c, z_edge_c, cnt_max_c;
  logic [CW1-1:0]   meas_c, exp_c, diff_c;
  logic             err_c, evt_c;

  // Edge detection, tolerance check and "error event this cycle" flag.
  // The measured delay is 0 when both edges land in the same IDLE sample.
  always_comb begin
    a_edge_c  = (mon.A != a_q);
    z_edge_c  = (mon.Z != z_q);
    cnt_max_c = (cnt_q == CNT_W'(MAX_WAIT));
    meas_c    = (state_q == WAIT) ? {1'b0, cnt_q} : '0;
    exp_c     = mon.Z ? CW1'(RISE_DLY) : CW1'(FALL_DLY);
    diff_c    = (meas_c >= exp_c) ? (meas_c - exp_c) : (exp_c - meas_c);
    err_c     = (32'(diff_c) > TOL);
    evt_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_edge_c) evt_c = z_edge_c & err_c;
        else          evt_c = z_edge_c;
      end
      WAIT: begin
        if (z_edge_c)      evt_c = err_c;
        else if (!a_edge_c) evt_c = cnt_max_c;
      end
    endcase
  end

  // Measurement FSM with registered result outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q       <= mon.A;
      z_q       <= mon.Z;
      state_q   <= IDLE;
      cnt_q     <= '0;
      delay_q   <= '0;
      edge_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      spur_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      a_q    <= mon.A;
      z_q    <= mon.Z;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tmo_q  <= 1'b0;
      spur_q <= 1'b0;
      if (evt_c && (err_cnt_q != CNT_SAT)) err_cnt_q <= err_cnt_q + 8'd1;
      case (state_q)
        IDLE: begin
          if (a_edge_c) begin
            if (z_edge_c) begin
              done_q  <= 1'b1;
              delay_q <= '0;
              edge_q  <= mon.Z;
              err_q   <= err_c;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(1);
            end
          end else if (z_edge_c) begin
            spur_q <= 1'b1;
          end
        end
        WAIT: begin
          if (z_edge_c) begin
            done_q  <= 1'b1;
            delay_q <= cnt_q;
            edge_q  <= mon.Z;
            err_q   <= err_c;
            // A new A edge in the same sample becomes the next reference.
            if (a_edge_c) cnt_q   <= CNT_W'(1);
            else          state_q <= IDLE;
          end else if (a_edge_c) begin
            // Input toggled before the output answered: restart silently.
            cnt_q <= CNT_W'(1);
          end else if (cnt_max_c) begin
            tmo_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign mon.DONE    = done_q;
  assign mon.DELAY   = delay_q;
  assign mon.EDGE    = edge_q;
  assign mon.ERR     = err_q;
  assign mon.TIMEOUT = tmo_q;
  assign mon.SPUR    = spur_q;
  assign mon.ERR_CNT = err_cnt_q;

endmodule
